i2s_rec_deserializer: RTL and testbench

Receive-side I2S deserializer for the SSM2603 record path. It oversamples `ac_bclk`, `ac_reclrc` and `ac_recdat` in the AXI-stream clock domain and assembles left/right sample pairs. Each pair is buffered as one 64-bit frame in a small FIFO and presented on an AXI4-Stream master toward the DMA. It is the record-side counterpart of the playback serializer inside the audio unit, and it sits between the codec pins and the upstream DMA channel.

---
 rtl/i2s_rec_deserializer.sv | 176 +++++++++++++++++
 tb/tb_i2s_rec_deserializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rec_deserializer.sv
// I2S record-path deserializer: oversamples the codec pins in the AXI-stream clock domain
// and delivers sign-extended left/right pairs as 64-bit frames through a small FWFT FIFO.
module i2s_rec_deserializer #(
   parameter int DATA_WIDTH  = 24,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int FRAME_LEN   = 256
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   input  logic        enable,
   input  logic        justification,
   input  logic        ac_bclk,
   input  logic        ac_reclrc,
   input  logic        ac_recdat,
   input  logic        m_axis_tready,
   output logic        m_axis_tvalid,
   output logic [63:0] m_axis_tdata,
   output logic        m_axis_tlast,
   output logic        rx_aligned,
   output logic [15:0] overflow_count
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_LEN - 1);
   localparam logic [AW:0]      CNT_MAX  = (AW + 1)'(FIFO_DEPTH);

   function automatic logic signed [31:0] sext(input logic signed [DATA_WIDTH-1:0] w);
      return 32'(w);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [SYNC_STAGES-1:0] bclk_sync, lrc_sync, dat_sync;
   logic bclk_prev_p0;
   logic bclk_s_p0, lrc_s_p0, dat_s_p0, bit_evt_p0;

   logic                         lrc_prev, aligned, left_valid;
   logic [CNT_W-1:0]             bit_cnt;
   logic signed [DATA_WIDTH-1:0] shift_p1, left_p1, right_p1, shift_nxt;
   logic                         vld_p1;
   logic                         lrc_edge, start_left;

   logic [63:0] frame_p2;
   logic        vld_p2;

   logic [63:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic [FC_W-1:0] frame_cnt;
   logic           full, pop, wr_en;

   // Stage p0: synchronizers and bit-event detection
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         bclk_sync    <= '0;
         lrc_sync     <= '0;
         dat_sync     <= '0;
         bclk_prev_p0 <= 1'b0;
      end else begin
         bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], ac_bclk};
         lrc_sync     <= {lrc_sync[SYNC_STAGES-2:0], ac_reclrc};
         dat_sync     <= {dat_sync[SYNC_STAGES-2:0], ac_recdat};
         bclk_prev_p0 <= bclk_s_p0;
      end
   end

   assign bclk_s_p0  = bclk_sync[SYNC_STAGES-1];
   assign lrc_s_p0   = lrc_sync[SYNC_STAGES-1];
   assign dat_s_p0   = dat_sync[SYNC_STAGES-1];
   assign bit_evt_p0 = bclk_s_p0 & ~bclk_prev_p0;

   assign lrc_edge   = lrc_s_p0 ^ lrc_prev;
   assign start_left = lrc_prev & ~lrc_s_p0;
   assign shift_nxt  = {shift_p1[DATA_WIDTH-2:0], dat_s_p0};

   // Stage p1: word capture; LRC history is tracked even while unaligned so realignment is exact
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         lrc_prev   <= 1'b0;
         aligned    <= 1'b0;
         left_valid <= 1'b0;
         bit_cnt    <= '0;
         shift_p1   <= '0;
         left_p1    <= '0;
         right_p1   <= '0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= 1'b0;
         if (bit_evt_p0) lrc_prev <= lrc_s_p0;
         if (!enable) begin
            aligned    <= 1'b0;
            left_valid <= 1'b0;
            bit_cnt    <= '0;
            shift_p1   <= '0;
         end else if (bit_evt_p0 && (aligned || start_left)) begin
            aligned <= 1'b1;
            if (lrc_edge) begin
               if (!lrc_s_p0) left_valid <= 1'b0;
               if (justification) begin
                  shift_p1 <= shift_nxt;
                  bit_cnt  <= CNT_W'(1);
               end else begin
                  bit_cnt  <= '0;
               end
            end else if (bit_cnt < CNT_FULL) begin
               shift_p1 <= shift_nxt;
               bit_cnt  <= bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_FULL - CNT_W'(1)) begin
                  if (!lrc_s_p0) begin
                     left_p1    <= shift_nxt;
                     left_valid <= 1'b1;
                  end else if (left_valid) begin
                     right_p1   <= shift_nxt;
                     vld_p1     <= 1'b1;
                     left_valid <= 1'b0;
                  end
               end
            end
         end
      end
   end

   // Stage p2: frame assembly with sign extension
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         frame_p2 <= '0;
         vld_p2   <= 1'b0;
      end else begin
         frame_p2 <= {sext(right_p1), sext(left_p1)};
         vld_p2   <= vld_p1;
      end
   end

   assign full  = (count == CNT_MAX);
   assign pop   = m_axis_tvalid & m_axis_tready;
   assign wr_en = vld_p2 & (~full | pop);

   // FIFO and packet framing; a full FIFO still accepts a push when a pop frees the slot
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         frame_cnt      <= '0;
         overflow_count <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= frame_p2;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (vld_p2 && !wr_en) overflow_count <= sat_inc(overflow_count);
      end
   end

   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = mem[rd_ptr];
   assign m_axis_tlast  = m_axis_tvalid & (frame_cnt == FC_LAST);
   assign rx_aligned    = aligned;

endmodule

// File: tb/tb_i2s_rec_deserializer.sv
// Directed bench for i2s_rec_deserializer: serial I2S/left-justified streams in, AXI frames checked out.
module tb_i2s_rec_deserializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        justification = 1'b0;
   logic        bclk = 1'b0;
   logic        lrc = 1'b0;
   logic        dat = 1'b0;
   logic        tready = 1'b0;
   logic        tvalid, tlast, aligned;
   logic [63:0] tdata;
   logic [15:0] ovf;

   int checks = 0;
   int errors = 0;
   int frame_no = 0;

   logic [64:0] frames[$];

   always #5 clk = ~clk;

   i2s_rec_deserializer #(
      .DATA_WIDTH(24), .SYNC_STAGES(2), .FIFO_DEPTH(4), .FRAME_LEN(4)
   ) dut (
      .axis_aclk(clk), .axis_aresetn(rst_n), .enable(enable), .justification(justification),
      .ac_bclk(bclk), .ac_reclrc(lrc), .ac_recdat(dat), .m_axis_tready(tready),
      .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
      .rx_aligned(aligned), .overflow_count(ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output monitor: records every handshake and checks that a stalled frame holds still.
   logic        pv = 1'b0, pr = 1'b0;
   logic [63:0] pd = '0;
   always @(negedge clk) begin
      if (rst_n && pv && !pr) begin
         checks++;
         assert (tvalid === 1'b1 && tdata === pd) else begin
            errors++;
            $error("FAIL axis_hold observed v=%b d=%h expected v=1 d=%h", tvalid, tdata, pd);
         end
      end
      if (tvalid === 1'b1 && tready === 1'b1) frames.push_back({tlast, tdata});
      pv = rst_n ? tvalid : 1'b0;
      pr = tready;
      pd = tdata;
   end

   function automatic logic [31:0] mk_slot(input logic [23:0] w, input logic lj);
      return lj ? {w, 8'h00} : {1'b0, w, 7'h00};
   endfunction

   task automatic bit_out(input logic l, input logic d, input logic meas);
      int cyc;
      @(posedge clk); #1;
      bclk = 1'b0; lrc = l; dat = d;
      repeat (4) @(posedge clk);
      #1 bclk = 1'b1;
      if (meas) begin
         cyc = 0;
         while (tvalid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("latency", 64'(cyc), 64'd5);
         chk("latency_tdata", tdata, 64'hFFABCDEF_00123456);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic send_slot(input logic l, input logic [31:0] s, input int nb, input int meas_k);
      for (int k = 0; k < nb; k++) bit_out(l, s[31-k], k == meas_k);
   endtask

   task automatic send_pair(input logic [23:0] lw, input logic [23:0] rw, input logic lj);
      send_slot(1'b0, mk_slot(lw, lj), 32, -1);
      send_slot(1'b1, mk_slot(rw, lj), 32, -1);
   endtask

   task automatic wait_frames(input string tag, input int n);
      int cyc = 0;
      while (frames.size() < n && cyc < 3000) begin
         @(posedge clk);
         cyc++;
      end
      chk(tag, 64'(frames.size() >= n), 64'd1);
   endtask

   task automatic check_frame(input string tag, input logic [63:0] exp);
      logic [64:0] f;
      if (frames.size() == 0) begin
         chk({tag, "_present"}, 64'd0, 64'd1);
      end else begin
         f = frames.pop_front();
         chk(tag, f[63:0], exp);
         chk({tag, "_tlast"}, 64'(f[64]), 64'((frame_no % 4) == 3));
         frame_no++;
      end
   endtask

   initial begin
      logic [64:0] f;
      logic [8:0]  tl_vec;

      repeat (3) @(posedge clk); #1;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tdata", tdata, 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      chk("rst_aligned", 64'(aligned), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);

      rst_n = 1'b1; enable = 1'b1; justification = 1'b0; tready = 1'b1;

      // I2S capture with latency measurement on the last right bit
      send_slot(1'b1, 32'h0, 32, -1);
      chk("pre_align", 64'(aligned), 64'd0);
      send_slot(1'b0, mk_slot(24'h123456, 1'b0), 32, -1);
      chk("aligned", 64'(aligned), 64'd1);
      send_slot(1'b1, mk_slot(24'hABCDEF, 1'b0), 32, 24);
      wait_frames("i2s_wait", 1);
      check_frame("i2s", 64'hFFABCDEF_00123456);

      // Left-justified, then a left-justified stream into I2S capture
      justification = 1'b1;
      send_pair(24'h123456, 24'hABCDEF, 1'b1);
      wait_frames("lj_wait", 1);
      check_frame("lj", 64'hFFABCDEF_00123456);
      justification = 1'b0;
      send_pair(24'h123456, 24'hABCDEF, 1'b1);
      wait_frames("shift_wait", 1);
      check_frame("shifted", 64'h00579BDE_002468AC);

      // Truncated right word
      send_slot(1'b0, mk_slot(24'h800001, 1'b0), 32, -1);
      send_slot(1'b1, mk_slot(24'h7FFFFF, 1'b0), 11, -1);
      send_pair(24'h800001, 24'h7FFFFF, 1'b0);
      repeat (20) @(posedge clk);
      chk("trunc_count", 64'(frames.size()), 64'd1);
      check_frame("trunc_next", 64'h007FFFFF_FF800001);
      chk("trunc_ovf", 64'(ovf), 64'd0);

      // Overflow with a stalled sink
      tready = 1'b0;
      for (int i = 1; i <= 6; i++) send_pair(24'hA00000 + 24'(i), 24'h100000 + 24'(i), 1'b0);
      #1;
      chk("ovf_tvalid", 64'(tvalid), 64'd1);
      chk("ovf_head", tdata, {32'h00100001, 32'hFFA00001});
      chk("ovf_count", 64'(ovf), 64'd2);
      chk("ovf_none_popped", 64'(frames.size()), 64'd0);
      @(posedge clk); #1 tready = 1'b1;
      wait_frames("drain_wait", 4);
      for (int i = 1; i <= 4; i++)
         check_frame("drain", {32'h00100000 + 32'(i), 32'hFFA00000 + 32'(i)});
      repeat (20) @(posedge clk); #1;
      chk("drain_extra", 64'(frames.size()), 64'd0);
      chk("drain_tvalid", 64'(tvalid), 64'd0);

      // Asynchronous reset mid right word
      send_slot(1'b0, mk_slot(24'h111111, 1'b0), 32, -1);
      send_slot(1'b1, mk_slot(24'h222222, 1'b0), 12, -1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(tvalid), 64'd0);
      chk("arst_tdata", tdata, 64'd0);
      chk("arst_tlast", 64'(tlast), 64'd0);
      chk("arst_aligned", 64'(aligned), 64'd0);
      chk("arst_ovf", 64'(ovf), 64'd0);
      repeat (3) @(posedge clk); #1 rst_n = 1'b1;
      frame_no = 0;
      send_slot(1'b1, 32'h0, 20, -1);
      chk("arst_no_partial", 64'(frames.size()), 64'd0);
      send_pair(24'h333333, 24'h444444, 1'b0);
      wait_frames("arst_wait", 1);
      check_frame("arst_next", 64'h00444444_00333333);

      // Enable dropped mid right word
      send_slot(1'b0, mk_slot(24'h555555, 1'b0), 32, -1);
      send_slot(1'b1, mk_slot(24'h666666, 1'b0), 12, -1);
      enable = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("en_aligned", 64'(aligned), 64'd0);
      enable = 1'b1;
      send_slot(1'b1, 32'h0, 20, -1);
      send_pair(24'h777777, 24'h123ABC, 1'b0);
      repeat (20) @(posedge clk);
      chk("en_count", 64'(frames.size()), 64'd1);
      check_frame("en_next", 64'h00123ABC_00777777);

      // Packet framing: tlast on frames 4 and 8 of 9
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      frame_no = 0;
      frames.delete();
      send_slot(1'b1, 32'h0, 32, -1);
      for (int i = 0; i < 9; i++) send_pair(24'h010000 + 24'(i), 24'hF00000 + 24'(i), 1'b0);
      wait_frames("pkt_wait", 9);
      tl_vec = '0;
      for (int i = 0; i < 9; i++) begin
         if (frames.size() != 0) begin
            f = frames.pop_front();
            tl_vec[i] = f[64];
            chk("pkt_data", f[63:0], {32'hFFF00000 + 32'(i), 32'h00010000 + 32'(i)});
         end
      end
      chk("pkt_tlast", 64'(tl_vec), 64'(9'b010001000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
